// File: rtl/scanner_pkg.sv
// Shared definitions for the scanner controller and the HEX status display decode.
// The state encoding doubles as the one-hot status word shown on the display.
package scanner_pkg;

    localparam int STATUS_W = 5;

    typedef enum logic [STATUS_W-1:0] {
        ST_IDLE     = 5'b01000,
        ST_SCAN     = 5'b10000,
        ST_STANDBY  = 5'b00010,
        ST_TRANSFER = 5'b00100,
        ST_FLUSH    = 5'b00001
    } scan_state_t;

endpackage

// File: rtl/scanner_ctrl_tick_gen.sv
// Progress prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
// clr restarts the count so the first tick lands exactly TICK_DIV clocks after it.
module tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/scanner_ctrl.sv
// Document scanner sequencer: IDLE -> SCAN -> STANDBY -> TRANSFER -> IDLE, plus FLUSH.
// Drives the one-hot display status, scan progress and a near-done launch pulse.
module scanner_ctrl
    import scanner_pkg::*;
#(
    parameter int TICK_DIV    = 25_000_000,
    parameter int SCAN_STEPS  = 10,
    parameter int NEAR_STEP   = 8,
    parameter int XFER_TICKS  = 4,
    parameter int FLUSH_TICKS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                xfer_en,
    input  logic                flush_req,
    output logic [STATUS_W-1:0] status,
    output logic [3:0]          progress,
    output logic                near_done,
    output logic                busy
);

    localparam int PH_MAX = (XFER_TICKS > FLUSH_TICKS) ? XFER_TICKS : FLUSH_TICKS;
    localparam int PH_W   = $clog2(PH_MAX) + 1;
    localparam logic [3:0]      PROG_LAST  = 4'(SCAN_STEPS - 1);
    localparam logic [3:0]      PROG_NEAR  = 4'(NEAR_STEP);
    localparam logic [PH_W-1:0] XFER_LAST  = PH_W'(XFER_TICKS - 1);
    localparam logic [PH_W-1:0] FLUSH_LAST = PH_W'(FLUSH_TICKS - 1);

    if (SCAN_STEPS < 1 || SCAN_STEPS > 16) begin : g_bad_scan_steps
        $error("scanner_ctrl: SCAN_STEPS must be 1..16 to fit the 4-bit progress port");
    end
    if (NEAR_STEP < 0 || NEAR_STEP >= SCAN_STEPS) begin : g_bad_near_step
        $error("scanner_ctrl: NEAR_STEP must be below SCAN_STEPS");
    end
    if (TICK_DIV < 2 || XFER_TICKS < 1 || FLUSH_TICKS < 1) begin : g_bad_ticks
        $error("scanner_ctrl: TICK_DIV must be >= 2 and phase tick counts >= 1");
    end

    scan_state_t     state, state_next;
    logic [3:0]      progress_next;
    logic [PH_W-1:0] phase, phase_next;
    logic            near_next;
    logic            tick, tick_en, tick_clr;

    assign tick_en  = (state == ST_SCAN) || (state == ST_TRANSFER) || (state == ST_FLUSH);
    assign tick_clr = (state_next != state);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tick_clr),
        .en      (tick_en),
        .tick    (tick)
    );

    always_comb begin
        state_next    = state;
        progress_next = progress;
        phase_next    = phase;
        case (state)
            ST_IDLE: begin
                if (flush_req)  state_next = ST_FLUSH;
                else if (start) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (tick) begin
                    if (progress == PROG_LAST) state_next = ST_STANDBY;
                    else                       progress_next = progress + 4'd1;
                end
            end
            ST_STANDBY: begin
                if (flush_req)    state_next = ST_FLUSH;
                else if (xfer_en) state_next = ST_TRANSFER;
            end
            ST_TRANSFER: begin
                if (tick) begin
                    if (phase == XFER_LAST) state_next = ST_IDLE;
                    else                    phase_next = phase + PH_W'(1);
                end
            end
            ST_FLUSH: begin
                if (tick) begin
                    if (phase == FLUSH_LAST) state_next = ST_IDLE;
                    else                     phase_next = phase + PH_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Phase restarts on every entry; progress is only meaningful in SCAN/STANDBY.
        if (state_next != state) phase_next = '0;
        if (state_next != ST_SCAN && state_next != ST_STANDBY) progress_next = '0;

        near_next = (state_next == ST_SCAN) && (progress_next == PROG_NEAR) &&
                    ((state != ST_SCAN) || tick);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            progress  <= '0;
            phase     <= '0;
            near_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            progress  <= progress_next;
            phase     <= phase_next;
            near_done <= near_next;
            busy      <= (state_next != ST_IDLE);
        end
    end

    assign status = state;

endmodule
